// File: rtl/imem_boot_loader.sv
// Boot loader: turns a byte stream into little-endian 32-bit words and writes them into instruction memory. It holds the core in reset until a complete image with a valid XOR checksum is loaded.
// Latency: imem_we pulses on the cycle after the 4th byte of a word is accepted. Peak rate is one word per 5 cycles.
// Backpressure: rx_ready is low during the write cycle, in DONE/ERROR and while rst is high. A byte offered while rx_ready is low stays with the source.
//
// Ports:
//   clk, rst                  : clock; synchronous active-high reset
//   rx_data/rx_valid/rx_ready : byte stream in (valid/ready)
//   imem_we/addr/wdata        : instruction-memory write port, one strobe per word
//   core_rst                  : high holds the core in reset; drops on entry to DONE
//   busy/done/error           : load status
//   error_code                : 00 none, 01 length overflow, 10 checksum mismatch
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code
);

    // The word index is one bit wider than the address so that a full
    // 2^ADDR_WIDTH-word image can be counted.
    localparam int          CW        = ADDR_WIDTH + 1;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CKSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      w_err_code_nxt;

    logic [7:0]      r_len_lo;
    logic [15:0]     r_len;
    logic [CW-1:0]   r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [31:0]     r_word;
    logic [7:0]      r_xor;

    logic            r_core_rst;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [1:0]      r_error_code;

    logic            w_rx_ready;
    logic            w_accept;
    logic [15:0]     w_len_rx;
    logic [CW-1:0]   w_idx_inc;

    // rx_ready depends only on state and rst, never on rx_valid, so there is
    // no combinational path from rx_valid to rx_ready.
    assign w_rx_ready = !rst && ((r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                                 (r_state == S_DATA)   || (r_state == S_CKSUM));
    assign w_accept   = rx_valid && w_rx_ready;
    assign w_len_rx   = {rx_data, r_len_lo};
    assign w_idx_inc  = r_word_idx + CW'(1);

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LEN_LO;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_core_rst   <= (w_state_nxt != S_DONE);
            r_busy       <= (w_state_nxt == S_DATA) || (w_state_nxt == S_WRITE) ||
                            (w_state_nxt == S_CKSUM);
            r_done       <= (w_state_nxt == S_DONE);
            r_error      <= (w_state_nxt == S_ERROR);
            r_error_code <= w_err_code_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_error_code;
        case (r_state)
            S_LEN_LO: begin
                if (w_accept) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len_rx} > MAX_WORDS) begin
                        w_state_nxt    = S_ERROR;
                        w_err_code_nxt = 2'b01;
                    end else if (w_len_rx == 16'd0) begin
                        w_state_nxt = S_CKSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (17'(w_idx_inc) == {1'b0, r_len}) w_state_nxt = S_CKSUM;
                else                                 w_state_nxt = S_DATA;
            end
            S_CKSUM: begin
                if (w_accept) begin
                    if (rx_data == r_xor) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_ERROR;
                        w_err_code_nxt = 2'b10;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_LEN_LO;
        endcase
    end

    // Length capture, word assembly, checksum accumulation and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
            r_xor      <= 8'd0;
        end else begin
            if ((r_state == S_LEN_LO) && w_accept) r_len_lo <= rx_data;
            if ((r_state == S_LEN_HI) && w_accept) r_len    <= w_len_rx;
            if ((r_state == S_DATA) && w_accept) begin
                // Little-endian: the first byte of a word lands in bits 7:0.
                r_word[{r_byte_idx, 3'b000} +: 8] <= rx_data;
                r_byte_idx                        <= r_byte_idx + 2'd1;
                r_xor                             <= r_xor ^ rx_data;
            end
            if (r_state == S_WRITE) r_word_idx <= w_idx_inc;
        end
    end

    // The write strobe is decoded from state and gated by rst. A reset that
    // arrives during the write cycle therefore suppresses that write.
    assign imem_we    = (r_state == S_WRITE) && !rst;
    assign imem_addr  = r_word_idx[ADDR_WIDTH-1:0];
    assign imem_wdata = r_word;
    assign rx_ready   = w_rx_ready;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign error_code = r_error_code;

endmodule
